// File: rtl/video_cfg_pkg.sv
// Shared constants, FSM state encoding and settings layout for the video
// configuration controller.
package video_cfg_pkg;

    localparam logic [7:0] TGT_SYS  = 8'h01;
    localparam logic [7:0] TGT_OSD  = 8'h02;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] BLOCK_ID = 8'hA6;

    localparam logic [2:0] IDX_SCANLINES = 3'd0;
    localparam logic [2:0] IDX_VOLUME    = 3'd1;
    localparam logic [2:0] IDX_WIDE      = 3'd2;
    localparam logic [2:0] IDX_VBLREGEN  = 3'd3;
    localparam logic [2:0] IDX_LIMIT     = 3'd4;

    localparam logic [1:0] RST_SCANLINES = 2'd0;
    localparam logic [1:0] RST_VOLUME    = 2'd2;
    localparam logic       RST_WIDE      = 1'b0;
    localparam logic       RST_VBLREGEN  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        TARGET,
        SYS_CMD,
        SYS_IDX,
        SYS_VAL,
        SYS_READ,
        OSD_FWD,
        DISCARD
    } cfg_state_t;

    typedef struct packed {
        logic [1:0] scanlines;
        logic [1:0] volume;
        logic       wide;
        logic       vblank_regen;
    } cfg_set_t;

    localparam cfg_set_t CFG_RESET = '{
        scanlines:    RST_SCANLINES,
        volume:       RST_VOLUME,
        wide:         RST_WIDE,
        vblank_regen: RST_VBLREGEN
    };

endpackage

// File: rtl/cfg_commit_sync.sv
// Shadow settings plus the commit path: vsync fall detect, no-vsync
// fallback timer and the pending flag.
module cfg_commit_sync
    import video_cfg_pkg::*;
#(
    parameter int COMMIT_TIMEOUT = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs_n,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    output cfg_set_t   active,
    output logic       pending
);

    logic                      vs_d1_q, vs_d1_d;
    logic                      vs_d2_q, vs_d2_d;
    logic [COMMIT_TIMEOUT-1:0] tmo_q, tmo_d;
    logic                      pending_q, pending_d;
    cfg_set_t                  shadow_q, shadow_d;
    cfg_set_t                  active_q, active_d;
    logic                      vs_fall;
    logic                      commit;
    logic                      wr_hit;

    always_comb begin
        vs_d1_d = vs_n;
        vs_d2_d = vs_d1_q;
        vs_fall = vs_d2_q & ~vs_d1_q;
        commit  = pending_q & (vs_fall | (&tmo_q));
        wr_hit  = wr_en & (wr_idx < IDX_LIMIT);

        // Commit copies the pre-write shadow, so a same-cycle write stays pending.
        active_d  = commit ? shadow_q : active_q;
        pending_d = wr_hit | (pending_q & ~commit);

        shadow_d = shadow_q;
        if (wr_en) begin
            case (wr_idx)
                IDX_SCANLINES: shadow_d.scanlines    = wr_data[1:0];
                IDX_VOLUME:    shadow_d.volume       = wr_data[1:0];
                IDX_WIDE:      shadow_d.wide         = wr_data[0];
                IDX_VBLREGEN:  shadow_d.vblank_regen = wr_data[0];
                default:       ;
            endcase
        end

        if (vs_fall || commit || !pending_q)
            tmo_d = '0;
        else
            tmo_d = tmo_q + {{(COMMIT_TIMEOUT-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d1_q   <= 1'b1;
            vs_d2_q   <= 1'b1;
            tmo_q     <= '0;
            pending_q <= 1'b0;
            shadow_q  <= CFG_RESET;
            active_q  <= CFG_RESET;
        end else begin
            vs_d1_q   <= vs_d1_d;
            vs_d2_q   <= vs_d2_d;
            tmo_q     <= tmo_d;
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign active  = active_q;
    assign pending = pending_q;

endmodule

// File: rtl/video_cfg_ctrl.sv
// MCU byte-stream parser: routes OSD messages to the overlay and system
// messages to the vsync-committed settings block.
module video_cfg_ctrl
    import video_cfg_pkg::*;
#(
    parameter int COMMIT_TIMEOUT = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mcu_start,
    input  logic       mcu_strobe,
    input  logic [7:0] mcu_data,
    input  logic       vs_n,
    input  logic       osd_status,
    output logic       osd_start,
    output logic       osd_strobe,
    output logic [7:0] osd_data,
    output logic [7:0] mcu_dout,
    output logic [1:0] system_scanlines,
    output logic [1:0] system_volume,
    output logic       system_wide_screen,
    output logic       vblank_regenerate,
    output logic       cfg_pending
);

    cfg_state_t state_q, state_d, cur;
    logic [2:0] idx_q, idx_d;
    logic [1:0] rd_cnt_q, rd_cnt_d;
    logic       osd_start_q, osd_start_d;
    logic       osd_strobe_q, osd_strobe_d;
    logic [7:0] osd_data_q, osd_data_d;
    logic [7:0] mcu_dout_q, mcu_dout_d;
    logic       wr_en;
    cfg_set_t   active;
    logic       pending;

    always_comb begin
        // A start pulse re-frames immediately; a same-cycle strobe is byte 0.
        cur          = mcu_start ? TARGET : state_q;
        state_d      = cur;
        idx_d        = idx_q;
        rd_cnt_d     = rd_cnt_q;
        osd_start_d  = 1'b0;
        osd_strobe_d = 1'b0;
        osd_data_d   = osd_data_q;
        mcu_dout_d   = mcu_dout_q;
        wr_en        = 1'b0;

        if (mcu_strobe) begin
            case (cur)
                TARGET: begin
                    if (mcu_data == TGT_SYS) begin
                        state_d = SYS_CMD;
                    end else if (mcu_data == TGT_OSD) begin
                        state_d     = OSD_FWD;
                        osd_start_d = 1'b1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                SYS_CMD: begin
                    if (mcu_data == CMD_WR) begin
                        state_d = SYS_IDX;
                    end else if (mcu_data == CMD_RD) begin
                        state_d  = SYS_READ;
                        rd_cnt_d = 2'd0;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                SYS_IDX: begin
                    idx_d   = mcu_data[2:0];
                    state_d = SYS_VAL;
                end
                SYS_VAL: begin
                    wr_en = 1'b1;
                    idx_d = (idx_q >= IDX_VBLREGEN) ? IDX_LIMIT : idx_q + 3'd1;
                end
                SYS_READ: begin
                    case (rd_cnt_q)
                        2'd0:    mcu_dout_d = {osd_status, pending, active.vblank_regen,
                                               active.wide, active.volume, active.scanlines};
                        2'd1:    mcu_dout_d = BLOCK_ID;
                        default: mcu_dout_d = 8'h00;
                    endcase
                    rd_cnt_d = (rd_cnt_q == 2'd2) ? 2'd2 : rd_cnt_q + 2'd1;
                end
                OSD_FWD: begin
                    osd_strobe_d = 1'b1;
                    osd_data_d   = mcu_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            rd_cnt_q     <= 2'd0;
            osd_start_q  <= 1'b0;
            osd_strobe_q <= 1'b0;
            osd_data_q   <= 8'h00;
            mcu_dout_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_cnt_q     <= rd_cnt_d;
            osd_start_q  <= osd_start_d;
            osd_strobe_q <= osd_strobe_d;
            osd_data_q   <= osd_data_d;
            mcu_dout_q   <= mcu_dout_d;
        end
    end

    cfg_commit_sync #(
        .COMMIT_TIMEOUT(COMMIT_TIMEOUT)
    ) u_commit (
        .clk     (clk),
        .rst     (reset),
        .vs_n    (vs_n),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (mcu_data),
        .active  (active),
        .pending (pending)
    );

    assign osd_start          = osd_start_q;
    assign osd_strobe         = osd_strobe_q;
    assign osd_data           = osd_data_q;
    assign mcu_dout           = mcu_dout_q;
    assign system_scanlines   = active.scanlines;
    assign system_volume      = active.volume;
    assign system_wide_screen = active.wide;
    assign vblank_regenerate  = active.vblank_regen;
    assign cfg_pending        = pending;

endmodule

// File: tb/tb_video_cfg_ctrl.sv
// Directed, table-driven bench for video_cfg_ctrl (COMMIT_TIMEOUT=4).
module tb_video_cfg_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mcu_start, mcu_strobe, vs_n, osd_status;
    logic [7:0] mcu_data;
    logic       osd_start, osd_strobe;
    logic [7:0] osd_data, mcu_dout;
    logic [1:0] system_scanlines, system_volume;
    logic       system_wide_screen, vblank_regenerate, cfg_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_cfg_ctrl #(.COMMIT_TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .mcu_start          (mcu_start),
        .mcu_strobe         (mcu_strobe),
        .mcu_data           (mcu_data),
        .vs_n               (vs_n),
        .osd_status         (osd_status),
        .osd_start          (osd_start),
        .osd_strobe         (osd_strobe),
        .osd_data           (osd_data),
        .mcu_dout           (mcu_dout),
        .system_scanlines   (system_scanlines),
        .system_volume      (system_volume),
        .system_wide_screen (system_wide_screen),
        .vblank_regenerate  (vblank_regenerate),
        .cfg_pending        (cfg_pending)
    );

    // Output snapshot: {osd_start, osd_strobe, osd_data, mcu_dout, scan, vol, wide, vbl, pending}
    typedef struct {
        logic        st;
        logic        sb;
        logic [7:0]  d;
        logic        vs;
        logic        os;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic st, input logic sb, input logic [7:0] d,
                                input logic vs, input logic os,
                                input logic ost, input logic ostb, input logic [7:0] od,
                                input logic [7:0] dout, input logic [1:0] sc,
                                input logic [1:0] vo, input logic wi, input logic vb,
                                input logic pe);
        vec_t v;
        v.st  = st;
        v.sb  = sb;
        v.d   = d;
        v.vs  = vs;
        v.os  = os;
        v.exp = {ost, ostb, od, dout, sc, vo, wi, vb, pe};
        return v;
    endfunction

    function automatic logic [24:0] snap();
        return {osd_start, osd_strobe, osd_data, mcu_dout, system_scanlines,
                system_volume, system_wide_screen, vblank_regenerate, cfg_pending};
    endfunction

    task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%07h expected 0x%07h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic st, input logic [7:0] d);
        mcu_start  = st;
        mcu_strobe = 1'b1;
        mcu_data   = d;
        step();
        mcu_start  = 1'b0;
        mcu_strobe = 1'b0;
        mcu_data   = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    localparam logic [24:0] RST_SNAP = {1'b0, 1'b0, 8'h00, 8'h00, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0};

    initial begin
        // st sb  d   vs os | ost stb od   dout  sc vo wi vb pe
        vecs[0]  = mk(1,1,8'h02,1,0, 1,0,8'h00,8'h00, 0,2,0,0,0);
        vecs[1]  = mk(0,1,8'h55,1,0, 0,1,8'h55,8'h00, 0,2,0,0,0);
        vecs[2]  = mk(0,0,8'h00,1,0, 0,0,8'h55,8'h00, 0,2,0,0,0);
        vecs[3]  = mk(0,1,8'hAA,1,0, 0,1,8'hAA,8'h00, 0,2,0,0,0);
        vecs[4]  = mk(0,0,8'h00,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,0);
        vecs[5]  = mk(1,1,8'h01,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,0);
        vecs[6]  = mk(0,1,8'h01,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,0);
        vecs[7]  = mk(0,1,8'h00,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,0);
        vecs[8]  = mk(0,1,8'h02,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,1);
        vecs[9]  = mk(0,1,8'h01,1,0, 0,0,8'hAA,8'h00, 0,2,0,0,1);
        vecs[10] = mk(0,0,8'h00,0,0, 0,0,8'hAA,8'h00, 0,2,0,0,1);
        vecs[11] = mk(0,0,8'h00,0,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[12] = mk(0,0,8'h00,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[13] = mk(1,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[14] = mk(0,1,8'h02,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[15] = mk(0,1,8'h00,1,1, 0,0,8'hAA,8'h86, 2,1,0,0,0);
        vecs[16] = mk(0,1,8'h00,1,1, 0,0,8'hAA,8'hA6, 2,1,0,0,0);
        vecs[17] = mk(0,1,8'h00,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[18] = mk(0,0,8'h00,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[19] = mk(1,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[20] = mk(0,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[21] = mk(1,1,8'h07,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[22] = mk(0,1,8'h03,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[23] = mk(0,1,8'h02,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[24] = mk(1,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[25] = mk(0,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[26] = mk(0,1,8'h02,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,0);
        vecs[27] = mk(0,1,8'h01,1,0, 0,0,8'hAA,8'h00, 2,1,0,0,1);
        vecs[28] = mk(0,0,8'h00,0,0, 0,0,8'hAA,8'h00, 2,1,0,0,1);
        vecs[29] = mk(0,1,8'h01,0,0, 0,0,8'hAA,8'h00, 2,1,1,0,1);
        vecs[30] = mk(0,0,8'h00,1,0, 0,0,8'hAA,8'h00, 2,1,1,0,1);

        reset      = 1'b1;
        mcu_start  = 1'b0;
        mcu_strobe = 1'b0;
        mcu_data   = 8'h00;
        vs_n       = 1'b1;
        osd_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", snap(), RST_SNAP);
        reset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            mcu_start  = vecs[i].st;
            mcu_strobe = vecs[i].sb;
            mcu_data   = vecs[i].d;
            vs_n       = vecs[i].vs;
            osd_status = vecs[i].os;
            step();
            chk($sformatf("vec[%0d]", i), snap(), vecs[i].exp);
        end
        mcu_start  = 1'b0;
        mcu_strobe = 1'b0;
        mcu_data   = 8'h00;
        vs_n       = 1'b1;
        osd_status = 1'b0;

        // Collided vblank write is committed by the fallback timer 16 clocks after the vsync commit.
        repeat (14) step();
        chk("tmo_collide_before", {23'd0, vblank_regenerate, cfg_pending}, {23'd0, 1'b0, 1'b1});
        step();
        chk("tmo_collide_after", {23'd0, vblank_regenerate, cfg_pending}, {23'd0, 1'b1, 1'b0});

        // Fresh timeout commit of wide=1 with vs_n held high.
        do_reset();
        chk("reset_again", snap(), RST_SNAP);
        send(1'b1, 8'h01);
        send(1'b0, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h01);
        chk("tmo_write_pending", {23'd0, system_wide_screen, cfg_pending}, {23'd0, 1'b0, 1'b1});
        repeat (15) step();
        chk("tmo_15_clocks", {23'd0, system_wide_screen, cfg_pending}, {23'd0, 1'b0, 1'b1});
        step();
        chk("tmo_16_clocks", {23'd0, system_wide_screen, cfg_pending}, {23'd0, 1'b1, 1'b0});

        // Reset asserted mid-SYS_VAL burst.
        send(1'b1, 8'h01);
        send(1'b0, 8'h01);
        send(1'b0, 8'h00);
        send(1'b0, 8'h01);
        chk("midval_pending", {24'd0, cfg_pending}, {24'd0, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        chk("midval_reset", snap(), RST_SNAP);
        #1;
        reset = 1'b0;
        step();

        // Strobes in IDLE without a start are ignored.
        send(1'b0, 8'h02);
        send(1'b0, 8'h55);
        chk("idle_strobe_ignored", snap(), RST_SNAP);
        vs_n = 1'b0;
        repeat (3) step();
        vs_n = 1'b1;
        step();
        chk("vsync_no_pending", snap(), RST_SNAP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_cfg_ctrl.md
# video_cfg_ctrl

MCU-side configuration controller for the video path. It decodes the byte stream arriving on the MCU SPI interface and routes each message to one of two places. OSD messages go unchanged to the `osd_u8g2` overlay. System messages write or read the user video/audio settings (`system_scanlines`, `system_volume`, `system_wide_screen`, `vblank_regenerate`). Setting writes are staged in shadow registers and committed at the next vertical sync, so scanline or volume changes never tear mid-frame.

## Interface
Parameters:
- `COMMIT_TIMEOUT`, default 21: width of the no-vsync fallback counter; a forced commit happens after 2^COMMIT_TIMEOUT clocks without vsync.

Ports:
- `clk` in 1: pixel/system clock.
- `reset` in 1: asynchronous, active-high.
- `mcu_start` in 1: message start pulse.
- `mcu_strobe` in 1: byte valid pulse.
- `mcu_data` in 8: MCU byte.
- `vs_n` in 1: active-low vsync, stabilised and in the `clk` domain.
- `osd_status` in 1: OSD visible flag.
- `osd_start` out 1: forwarded start pulse.
- `osd_strobe` out 1: forwarded strobe.
- `osd_data` out 8: forwarded byte.
- `mcu_dout` out 8: read-back byte.
- `system_scanlines` out 2: committed value; reset value 0.
- `system_volume` out 2: committed value; reset value 2.
- `system_wide_screen` out 1: committed value; reset value 0.
- `vblank_regenerate` out 1: committed value; reset value 0.
- `cfg_pending` out 1: shadow holds uncommitted writes; reset value 0.

Other outputs reset to 0.

## Operation
- Message framing:
  - Byte 0 is the target byte: `TGT_SYS`=0x01, `TGT_OSD`=0x02.
  - The byte strobed in the same cycle as `mcu_start`, or the first strobe after it, is byte 0.
  - `mcu_start` at any point aborts the current message and returns the FSM to `TARGET`. Partial writes already in the shadow stay.
- FSM states:
  - `IDLE`: wait for `mcu_start`.
  - `TARGET`: byte 0 selects the next state.
    - 0x01 → `SYS_CMD`.
    - 0x02 → `OSD_FWD`, with a one-cycle `osd_start` pulse.
    - Any other value → `DISCARD`.
  - `SYS_CMD`: the command byte selects the next state.
    - `CMD_WR`=0x01 → `SYS_IDX`.
    - `CMD_RD`=0x02 → `SYS_READ`.
    - Any other value → `DISCARD`.
  - `SYS_IDX`: latch a 3-bit index from `mcu_data[2:0]`, then → `SYS_VAL`.
  - `SYS_VAL`: each byte writes `shadow[idx]` and then increments idx (burst write).
    - idx 0 = scanlines, from bits [1:0].
    - idx 1 = volume, from bits [1:0].
    - idx 2 = wide, from bit [0].
    - idx 3 = vblank_regen, from bit [0].
    - idx ≥ 4: the byte is ignored and idx saturates at 4.
  - `SYS_READ`: on each strobe, `mcu_dout` is loaded as follows.
    - First strobe: status `{osd_status, cfg_pending, vblank_regen, wide, volume, scanlines}`, zero-extended to 8 bits.
    - Second strobe: 0xA6 (block ID).
    - Later strobes: 0x00.
  - `OSD_FWD`: every strobe → `osd_strobe`=1 and `osd_data`=`mcu_data`. Stays here until the next `mcu_start`.
  - `DISCARD`: ignore all bytes until `mcu_start`.
- Commit:
  - A falling edge of `vs_n` (registered, old=1/new=0) copies shadow → active outputs when `cfg_pending`=1.
  - A forced commit fires when the timeout counter reaches all-ones while `cfg_pending`=1. The counter clears on every `vs_n` falling edge and on every commit.
- `cfg_pending`:
  - Set by any in-range `SYS_VAL` write.
  - Cleared by a commit.
  - A write landing in the same cycle as a commit is not included in that commit, and `cfg_pending` stays 1.

## Timing
- Forwarding latency: `osd_start`, `osd_strobe` and `osd_data` are registered and appear one clock after the input strobe.
- Read-back: `mcu_dout` is valid one clock after the strobe and held until the next update.
- Commit: active outputs change on the clock after the edge-detect register sees the `vs_n` fall, i.e. 2 clocks after `vs_n` goes low.
- Reset mid-message: FSM → `IDLE`; shadow and active registers → reset values; `cfg_pending`=0.
- Strobes while in `IDLE` with no preceding start are ignored.

## Structure
- Package `video_cfg_pkg`:
  - Target constants `TGT_SYS` and `TGT_OSD`.
  - Command constants `CMD_WR` and `CMD_RD`.
  - Index constants `IDX_SCANLINES`, `IDX_VOLUME`, `IDX_WIDE`, `IDX_VBLREGEN`.
  - FSM state enum `cfg_state_t`.
  - Reset values of the four settings.
- One sub-module, `cfg_commit_sync`, holds the shadow→active commit logic: `vs_n` edge detect, timeout counter and pending flag. The parser FSM stays in the top level.

## Test plan
- Forwarding: start, bytes 0x02,0x55,0xAA → one `osd_start` pulse; `osd_strobe`/`osd_data` = 0x55 then 0xAA, each 1 clock after its input strobe; all system outputs unchanged.
- Burst write and commit: start, 0x01,0x01,0x00,0x02,0x01 → scanlines still 0 and `cfg_pending`=1; after `vs_n` falls, scanlines=2 and volume=1 two clocks later; `cfg_pending`=0.
- Read-back: after the previous test, start, 0x01,0x02, strobe, strobe with `osd_status`=1 → `mcu_dout`=0x86 (osd_status=1, pending=0, vblank_regen=0, wide=0, volume=1, scanlines=2), then 0xA6.
- Timeout commit: write wide=1 with `vs_n` held high; with `COMMIT_TIMEOUT`=4, commit occurs after 16 clocks.
- Abort and unknown target: start, 0x01,0x01 then a new start, 0x07,0x03 → no shadow change, no OSD strobes, `cfg_pending`=0.
- Write/commit collision and reset: a write coincident with the `vs_n` commit edge is not applied and `cfg_pending` stays 1; asserting `reset` mid-`SYS_VAL` restores volume=2 and all other outputs to 0.
